// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the two-requester run timer arbiter.
// The optional 7-segment encoder (TIMER_ARB_SEG_EN) uses the segment constants.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Last-served pointer after reset: requester 0 wins the first tie
  localparam logic PTR_RST = 1'b1;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (d)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler: counts 0..SEC_CNT-1 while enabled, tick on the last count.
module sec_tick_gen #(
  parameter int unsigned SEC_CNT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (SEC_CNT > 1) ? $clog2(SEC_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SEC_CNT - 1);

  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (i_clr) begin
      tick_cnt <= '0;
    end else if (i_en) begin
      tick_cnt <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Combinational so the owner FSM reacts in the same cycle as the last count
  assign o_tick = i_en && (tick_cnt == CNT_MAX);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one seconds countdown timer between two requesters.
// Define TIMER_ARB_SEG_EN to add the registered 7-segment owner/remain display.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned SEC_CNT = 10,
  parameter int unsigned DUR_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_req,
  input  logic [DUR_W-1:0] i_dur0,
  input  logic [DUR_W-1:0] i_dur1,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic [1:0]       o_done,
  output logic [1:0]       o_abort,
  output logic [DUR_W-1:0] o_remain
`ifdef TIMER_ARB_SEG_EN
  ,
  output logic [6:0]       o_seven0,
  output logic [6:0]       o_seven1
`endif
);

  state_e           state, state_nxt;
  logic             ptr, ptr_nxt;
  logic             owner, owner_nxt;
  logic [1:0]       gnt_nxt, done_nxt, abort_nxt;
  logic [DUR_W-1:0] remain_nxt;
  logic [DUR_W-1:0] own_dur_c;
  logic             own_req_c;
  logic             win_c;
  logic             tick_c;

  sec_tick_gen #(
    .SEC_CNT (SEC_CNT)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (state == RUN),
    .i_clr  (state == GRANT),
    .o_tick (tick_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      owner    <= 1'b0;
      o_gnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= '0;
      o_abort  <= '0;
      o_remain <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      o_gnt    <= gnt_nxt;
      o_busy   <= (state_nxt != IDLE);
      o_done   <= done_nxt;
      o_abort  <= abort_nxt;
      o_remain <= remain_nxt;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    gnt_nxt    = o_gnt;
    done_nxt   = '0;
    abort_nxt  = '0;
    remain_nxt = o_remain;
    win_c      = 1'b0;
    own_dur_c  = owner ? i_dur1 : i_dur0;
    own_req_c  = i_req[owner];

    case (state)
      IDLE: begin
        gnt_nxt    = '0;
        remain_nxt = '0;
        if (|i_req) begin
          // On a tie the requester not served last wins
          win_c     = (i_req == 2'b11) ? ~ptr : i_req[1];
          state_nxt = GRANT;
          ptr_nxt   = win_c;
          owner_nxt = win_c;
          gnt_nxt   = win_c ? 2'b10 : 2'b01;
        end
      end
      GRANT: begin
        remain_nxt = own_dur_c;
        if (own_dur_c != '0) begin
          state_nxt = RUN;
        end else begin
          state_nxt = DONE;
          done_nxt  = o_gnt;
        end
      end
      RUN: begin
        // A dropped request beats a same-cycle final tick
        if (!own_req_c) begin
          state_nxt = DONE;
          abort_nxt = o_gnt;
        end else if (tick_c) begin
          remain_nxt = o_remain - DUR_W'(1);
          if (o_remain == DUR_W'(1)) begin
            state_nxt = DONE;
            done_nxt  = o_gnt;
          end
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        gnt_nxt    = '0;
        remain_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef TIMER_ARB_SEG_EN
  logic [3:0] digit_c;

  always_comb begin
    digit_c = (32'(o_remain) > 32'd9) ? 4'hF : 4'(o_remain);
  end

  // Display follows the registered outputs, one cycle behind o_remain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_seven0 <= SEG_BLANK;
      o_seven1 <= SEG_BLANK;
    end else begin
      o_seven0 <= o_busy ? seg_digit(digit_c) : SEG_DASH;
      o_seven1 <= o_busy ? (owner ? SEG_1 : SEG_0) : SEG_BLANK;
    end
  end
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter (SEC_CNT=4, DUR_W=3): vector table plus
// hand-written corner sequences, completion pulses checked against a scoreboard queue.
module tb_timer_arbiter;

  localparam int unsigned SEC_CNT = 4;
  localparam int unsigned DUR_W   = 3;

  typedef struct {
    logic [1:0] req;
    logic [2:0] d0;
    logic [2:0] d1;
    int         drop;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [1:0] abort;
    int         len;
  } vec_t;

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] done;
    logic [1:0] abort;
    int         len;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       i_req;
  logic [DUR_W-1:0] i_dur0, i_dur1;
  logic [1:0]       o_gnt, o_done, o_abort;
  logic             o_busy;
  logic [DUR_W-1:0] o_remain;
`ifdef TIMER_ARB_SEG_EN
  logic [6:0]       o_seven0, o_seven1;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_len = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];

  timer_arbiter #(
    .SEC_CNT (SEC_CNT),
    .DUR_W   (DUR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_dur0   (i_dur0),
    .i_dur1   (i_dur1),
    .o_gnt    (o_gnt),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_abort  (o_abort),
    .o_remain (o_remain)
`ifdef TIMER_ARB_SEG_EN
    ,
    .o_seven0 (o_seven0),
    .o_seven1 (o_seven1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [1:0] g, input logic [1:0] d,
                                  input logic [1:0] a, input int l);
    exp_t e;
    e.gnt = g; e.done = d; e.abort = a; e.len = l;
    return e;
  endfunction

  // Scoreboard: every done/abort pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0;
    end else if (o_done != 2'b00 || o_abort != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, o_done, o_abort}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_gnt", 32'(o_gnt), 32'(mon_e.gnt));
        check("pulse_done", 32'(o_done), 32'(mon_e.done));
        check("pulse_abort", 32'(o_abort), 32'(mon_e.abort));
        check("busy_cycles_before_pulse", busy_len, mon_e.len);
      end
      busy_len = 0;
    end else if (o_busy) begin
      busy_len++;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((o_done | o_abort) == 2'b00 && n < 300);
    if ((o_done | o_abort) == 2'b00) check({tag, "_pulse_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    wait_idle(tag);
    i_req  = v.req;
    i_dur0 = v.d0;
    i_dur1 = v.d1;
    exp_q.push_back(mk_exp(v.gnt, v.done, v.abort, v.len));
    @(posedge clk); #1;
    check({tag, "_gnt"}, 32'(o_gnt), 32'(v.gnt));
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    if (v.drop >= 0) begin
      repeat (v.drop + 1) @(posedge clk);
      #1;
      i_req = 2'b00;
    end
    wait_pulse(tag);
    i_req = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    logic [1:0] rr_exp[3];

    //            req    d0    d1   drop gnt    done   abort  len
    vecs[0] = '{2'b01, 3'd3, 3'd0, -1, 2'b01, 2'b01, 2'b00, 13};
    vecs[1] = '{2'b11, 3'd1, 3'd2, -1, 2'b10, 2'b10, 2'b00,  9};
    vecs[2] = '{2'b11, 3'd2, 3'd1, -1, 2'b01, 2'b01, 2'b00,  9};
    vecs[3] = '{2'b01, 3'd0, 3'd4, -1, 2'b01, 2'b01, 2'b00,  1};
    vecs[4] = '{2'b10, 3'd2, 3'd5,  6, 2'b10, 2'b00, 2'b10,  8};
    vecs[5] = '{2'b11, 3'd1, 3'd1, -1, 2'b01, 2'b01, 2'b00,  5};
    vecs[6] = '{2'b10, 3'd0, 3'd7, -1, 2'b10, 2'b10, 2'b00, 29};

    reset  = 1'b1;
    i_req  = 2'b00;
    i_dur0 = '0;
    i_dur1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_abort", 32'(o_abort), 32'd0);
    check("rst_remain", 32'(o_remain), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("idle_no_req_busy", 32'(o_busy), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Countdown of o_remain, one step per 4 RUN cycles
    wait_idle("remain");
    i_req  = 2'b01;
    i_dur0 = 3'd3;
    exp_q.push_back(mk_exp(2'b01, 2'b01, 2'b00, 13));
    @(posedge clk); #1;
    check("remain_gnt", 32'(o_gnt), 32'd1);
    @(posedge clk); #1;
    check("remain_run_entry", 32'(o_remain), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check("remain_after_tick1", 32'(o_remain), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("remain_before_tick2", 32'(o_remain), 32'd2);
    @(posedge clk); #1;
    check("remain_after_tick2", 32'(o_remain), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("remain_final", 32'(o_remain), 32'd0);
    check("remain_done", 32'(o_done), 32'd1);
    i_req = 2'b00;

    // Held tie alternates owners with exactly one IDLE cycle between runs
    wait_idle("rr");
    rr_exp[0] = 2'b10;
    rr_exp[1] = 2'b01;
    rr_exp[2] = 2'b10;
    i_req  = 2'b11;
    i_dur0 = 3'd1;
    i_dur1 = 3'd1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(rr_exp[k], rr_exp[k], 2'b00, 5));
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        @(posedge clk); #1;
        if (!o_busy) gap++;
      end while (!o_busy && gap < 50);
      check($sformatf("rr%0d_gnt", k), 32'(o_gnt), 32'(rr_exp[k]));
      if (k > 0) check($sformatf("rr%0d_idle_gap", k), gap, 32'd1);
      wait_pulse($sformatf("rr%0d", k));
    end
    i_req = 2'b00;

    // Reset in the middle of a run clears everything at once
    wait_idle("midrst");
    i_req  = 2'b01;
    i_dur0 = 3'd3;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (o_remain != 3'd2 && gap < 50);
    check("midrst_reached_remain2", 32'(o_remain), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_gnt", 32'(o_gnt), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_abort", 32'(o_abort), 32'd0);
    check("midrst_remain", 32'(o_remain), 32'd0);
    i_req  = 2'b11;
    i_dur0 = 3'd1;
    i_dur1 = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(mk_exp(2'b01, 2'b01, 2'b00, 5));
    @(posedge clk); #1;
    check("post_rst_tie_gnt", 32'(o_gnt), 32'd1);
    wait_pulse("post_rst");
    i_req = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one seconds-based run timer between two requesters on the FPGA board design. A round-robin arbiter grants the timer, counts down the granted requester's programmed duration in seconds and returns a done pulse (or an abort pulse). With the optional display enabled, it also drives the 7-segment display with the owner and remaining time. It sits between the front-panel or user-logic requesters and the stopwatch/LED display logic, and replaces ad-hoc run/idle sequencing.

## Interface
- SEC_CNT, 10: clock cycles per one-second tick; legal range 2..65535.
- DUR_W, 3: width of duration fields in seconds.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  2  per-requester level request; bit i belongs to requester i.
- i_dur0  input  DUR_W  requester 0 run duration in seconds; sampled at grant.
- i_dur1  input  DUR_W  requester 1 run duration in seconds; sampled at grant.
- o_gnt  output  2  one-hot grant; held from GRANT through DONE.
- o_busy  output  1  timer owned (state is not IDLE).
- o_done  output  2  one-cycle pulse to the owner on normal completion.
- o_abort  output  2  one-cycle pulse to the owner when it dropped its request early.
- o_remain  output  DUR_W  seconds remaining; 0 when idle.
- o_seven0, o_seven1  output  7  each; active-low segments (present only with TIMER_ARB_SEG_EN).

## Operation
- States:
  - IDLE: wait for any i_req bit.
  - GRANT: latch the winner's duration into remain; clear the prescaler.
  - RUN: count down.
  - DONE: issue the pulse, then return to IDLE.
- Arbitration: round-robin on a last-served pointer.
  - If both requesters request in IDLE, the one not last served wins.
  - The pointer updates on entry to GRANT.
  - After reset the pointer is 1, so requester 0 wins the first tie.
- A single request is granted regardless of the pointer.
- IDLE to GRANT happens when (|i_req). GRANT to RUN happens when the latched duration is nonzero; a duration of 0 goes GRANT to DONE with o_done.
- Prescaler: tick_cnt counts 0..SEC_CNT-1; a tick is asserted when tick_cnt == SEC_CNT-1, then tick_cnt wraps to 0. The prescaler counts only in RUN.
- remain decrements on each tick. A tick with remain == 1 moves RUN to DONE, and remain becomes 0.
- Abort: if the owner's i_req is low in RUN, the FSM goes to DONE next edge with o_abort instead of o_done. This takes priority over a same-cycle final tick.
- Requests from the non-owner are ignored until IDLE; no preemption.
- A requester still requesting in IDLE after its own DONE competes normally. The round-robin pointer ensures it loses a tie.
- Duration width is fixed at DUR_W; no saturation needed. The maximum run is (2^DUR_W - 1)*SEC_CNT cycles.

## Timing
- Reset values:
  - Registers: state IDLE, o_gnt 0, o_busy 0, o_done 0, o_abort 0, o_remain 0, pointer 1, tick_cnt 0.
  - Segment outputs: 7'b111_1111 (blank).
- All outputs are registered.
- Request seen high at edge k in IDLE: at k+1, o_gnt and o_busy are high and the state is GRANT; the state is RUN at k+2.
- RUN lasts exactly dur*SEC_CNT cycles absent abort. DONE lasts 1 cycle, with o_done/o_abort high for that cycle only.
- o_gnt and o_busy fall on the edge leaving DONE. The earliest re-grant is 1 cycle later, because a single IDLE cycle is mandatory.
- o_remain shows the latched duration from RUN entry and updates on the edge following each tick.
- Reset asserted mid-RUN returns all outputs to their reset values immediately. No done or abort pulse is emitted.

## Configuration
- TIMER_ARB_SEG_EN defined: o_seven0 and o_seven1 ports exist.
  - o_seven0 shows the remain digit 0-9, or "-" when idle.
  - o_seven1 shows the owner "0"/"1", or blank when idle.
  - Active-low, registered, one cycle behind o_remain.
- TIMER_ARB_SEG_EN undefined: the ports and encoder logic are absent. All other behaviour is identical.

## Structure
- Package timer_arb_pkg:
  - state encoding IDLE=2'b00, GRANT=2'b01, RUN=2'b10, DONE=2'b11;
  - 7-segment constants for digits 0-9, dash and blank;
  - a localparam for the reset pointer value.
- Sub-module sec_tick_gen (parameter SEC_CNT; inputs clk, reset, i_en, i_clr; output o_tick). It is the natural split and can be reused by other stopwatch blocks.
- The arbiter, FSM and countdown stay in timer_arbiter.

## Test plan
Test plan uses SEC_CNT=4.
1. Reset for 3 cycles, then release with no requests → all outputs at reset values, o_busy 0 indefinitely.
2. i_req=2'b01, i_dur0=3 → o_gnt=01 next edge; o_remain 3→2→1→0 every 4 cycles; o_done=01 for 1 cycle after 12 RUN cycles; o_busy falls.
3. i_req=2'b11 held continuously with durations 1 and 1 → grants alternate 01, 10, 01…, each separated by exactly one IDLE cycle.
4. i_req=2'b10, i_dur1=5; drop i_req[1] after 6 RUN cycles → o_abort=10 one cycle, o_done stays 0, o_gnt clears.
5. i_dur0=0 request → GRANT then DONE directly; o_done=01 two cycles after the request is sampled; RUN is never entered.
6. Assert reset mid-RUN with o_remain=2 → outputs return to reset values asynchronously; no pulses; a fresh request after release is granted to requester 0 on a tie.
